mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- CPU-side initiator for data memory: takes one load/store request per transaction and drives a word-only memory port with a req/ack handshake.
- Loads: reads the word, then extracts and extends the selected byte or halfword.
- Stores: sw is a direct word write; sh/sb are read-modify-write (RMW).
- Sits between the execute stage and the word-wide data memory; stalls the CPU via cpu_busy.

Parameters:
- TIMEOUT, 255: max cycles to wait for mem_ack per memory access; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_ld  in  1  load request, sampled in IDLE only
- cpu_st  in  1  store request, sampled in IDLE only
- l_mux  in  3  000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu
- s_mux  in  2  00 sw, 01 sh, 10 sb
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data; sh uses [15:0], sb uses [7:0]
- cpu_rdata  out  32  load result; held until the next load completes
- cpu_done  out  1  one-cycle completion pulse
- cpu_busy  out  1  high whenever state is not IDLE
- cpu_err  out  1  one-cycle pulse, coincident with cpu_done, on a failed request
- mem_req  out  1  memory access request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  32  word address, {cpu_addr[31:2],2'b00}
- mem_wdata  out  32  full write word
- mem_rdata  in  32  read word, valid when mem_ack=1 and mem_we=0
- mem_ack  in  1  access complete, sampled on rising edge

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0, including cpu_rdata; timeout counter 0.
- Reset mid-transaction aborts immediately and drops mem_req. A write already acked by memory stands; no other partial effects.
- States: IDLE, RD, WR, DONE.
- IDLE: request inputs are latched into internal registers on the cycle of acceptance. Next state:
  - Illegal request goes to DONE with cpu_err=1 and no memory access. Illegal means any of:
    - cpu_ld and cpu_st both high
    - l_mux 101–111
    - s_mux 11
    - misaligned address: lw/sw need addr[1:0]=00; lh/lhu/sh need addr[0]=0
  - Legal load goes to RD.
  - Legal sw goes to WR with mem_wdata=cpu_wdata.
  - Legal sh/sb go to RD.
  - No request: stay in IDLE.
- RD: mem_req=1, mem_we=0. On mem_ack:
  - Load: write the extracted value to cpu_rdata, go to DONE. Extraction:
    - lh/lhu: addr[1]=0 selects [15:0], addr[1]=1 selects [31:16]; lh sign-extends, lhu zero-extends.
    - lb/lbu: addr[1:0] selects byte lane n, bits [8n+7:8n]; lb sign-extends, lbu zero-extends.
  - sh/sb: register the merged word, go to WR. Merge: replace only the addressed halfword/byte lane with cpu_wdata[15:0]/[7:0]; other bits come from mem_rdata.
- WR: mem_req=1, mem_we=1, mem_wdata stable. On mem_ack, go to DONE.
- DONE: cpu_done=1 for exactly one cycle, then IDLE. Requests are not sampled in DONE.
- Handshake:
  - mem_req, mem_we, mem_addr and mem_wdata are held constant from entering RD/WR until the cycle mem_ack is seen.
  - mem_ack is legal in the first cycle mem_req is high (zero-wait memory).
  - mem_ack while mem_req=0 is ignored.
  - mem_req drops in the cycle after the ack.
- Latency from the acceptance edge to the cpu_done cycle, zero-wait memory:
  - load and sw: 2 cycles
  - sh/sb: 3 cycles
  - each wait cycle adds 1 per access
- Timeout (TIMEOUT>0):
  - Counter clears on entering RD/WR and increments each cycle without ack.
  - When the count reaches TIMEOUT: drop mem_req, go to DONE with cpu_err=1.
  - On timeout, cpu_rdata is unchanged; an RMW store performs no write.
- cpu_rdata updates only on a successful load; stores and errors leave it unchanged.
- Requests presented while cpu_busy=1 are ignored. The CPU holds cpu_ld/cpu_st low after cpu_done until its next request.

Test Plan:
- Reset then lbu at 0x103, memory word 0x80FF_1234 with zero wait → mem_addr=0x100, mem_we=0; cpu_done 2 cycles after accept; cpu_rdata=0x0000_0080. Repeat as lb → 0xFFFF_FF80.
- lh at 0x102, word 0x8001_7FFF, ack delayed 3 cycles → mem_req held high for 4 cycles with constant address; cpu_rdata=0xFFFF_8001; lhu → 0x0000_8001.
- sb at 0x201, cpu_wdata=0xAABB_CCDD, memory word 0x1122_3344 → read then write; mem_wdata=0x1122_DD44; cpu_done 3 cycles after accept.
- sw at 0x002 and lh at 0x101 → no mem_req; cpu_done and cpu_err pulse together in cycle 1; cpu_rdata unchanged. cpu_ld and cpu_st both high → same error response.
- TIMEOUT=4 and memory never acks a sw → mem_req high for 4 cycles, then cpu_err; back to IDLE; a following lw completes normally.
- Assert rst_n low while in WR before ack → all outputs 0 asynchronously; state IDLE after release; a new request is accepted on the next cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Load/store initiator for a word-wide data memory with req/ack,
//            sub-word extraction and read-modify-write for sh/sb.
// Revision : 1.0
// ============================================================================
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_ld,
    input  logic        cpu_st,
    input  logic [2:0]  l_mux,
    input  logic [1:0]  s_mux,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_done,
    output logic        cpu_busy,
    output logic        cpu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned c_TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_is_load;
    logic [2:0]        r_lmux;
    logic [1:0]        r_smux;
    logic [1:0]        r_alo;
    logic [31:0]       r_wdata;
    logic [c_TW-1:0]   r_tcnt;

    logic              w_ld_bad;
    logic              w_st_bad;
    logic              w_illegal;
    logic [c_TW-1:0]   w_tcnt_next;
    logic              w_timeout;
    logic [15:0]       w_half;
    logic [7:0]        w_byte;
    logic [31:0]       w_load_val;
    logic [31:0]       w_merged;

    assign cpu_busy = (r_state != S_IDLE);

    always_comb begin
        w_ld_bad = (l_mux > 3'd4)
                 || ((l_mux == 3'd0) && (cpu_addr[1:0] != 2'b00))
                 || (((l_mux == 3'd1) || (l_mux == 3'd2)) && cpu_addr[0]);
        w_st_bad = (s_mux == 2'd3)
                 || ((s_mux == 2'd0) && (cpu_addr[1:0] != 2'b00))
                 || ((s_mux == 2'd1) && cpu_addr[0]);
        w_illegal = (cpu_ld && cpu_st) || (cpu_ld && w_ld_bad) || (cpu_st && w_st_bad);
    end

    assign w_tcnt_next = r_tcnt + 1'b1;
    assign w_timeout   = (TIMEOUT != 0) && (w_tcnt_next == c_TW'(TIMEOUT));

    // Sub-word extraction for loads, driven from the latched request.
    always_comb begin
        w_half     = r_alo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        w_byte     = mem_rdata[{r_alo, 3'b000} +: 8];
        w_load_val = mem_rdata;
        case (r_lmux)
            3'd1:    w_load_val = {{16{w_half[15]}}, w_half};
            3'd2:    w_load_val = {16'h0000, w_half};
            3'd3:    w_load_val = {{24{w_byte[7]}}, w_byte};
            3'd4:    w_load_val = {24'h000000, w_byte};
            default: w_load_val = mem_rdata;
        endcase
    end

    always_comb begin
        w_merged = mem_rdata;
        if (r_smux == 2'd1) begin
            if (r_alo[1]) w_merged[31:16] = r_wdata[15:0];
            else          w_merged[15:0]  = r_wdata[15:0];
        end else begin
            w_merged[{r_alo, 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_is_load <= 1'b0;
            r_lmux    <= 3'd0;
            r_smux    <= 2'd0;
            r_alo     <= 2'd0;
            r_wdata   <= 32'h0;
            r_tcnt    <= '0;
            cpu_rdata <= 32'h0;
            cpu_done  <= 1'b0;
            cpu_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            cpu_done <= 1'b0;
            cpu_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_ld || cpu_st) begin
                        r_is_load <= cpu_ld;
                        r_lmux    <= l_mux;
                        r_smux    <= s_mux;
                        r_alo     <= cpu_addr[1:0];
                        r_wdata   <= cpu_wdata;
                        r_tcnt    <= '0;
                        mem_addr  <= {cpu_addr[31:2], 2'b00};
                        if (w_illegal) begin
                            r_state  <= S_DONE;
                            cpu_done <= 1'b1;
                            cpu_err  <= 1'b1;
                        end else if (cpu_ld || (s_mux != 2'd0)) begin
                            r_state <= S_RD;
                            mem_req <= 1'b1;
                            mem_we  <= 1'b0;
                        end else begin
                            r_state   <= S_WR;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_wdata <= cpu_wdata;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        if (r_is_load) begin
                            cpu_rdata <= w_load_val;
                            mem_req   <= 1'b0;
                            r_state   <= S_DONE;
                            cpu_done  <= 1'b1;
                        end else begin
                            // RMW: request stays up and turns into the write.
                            mem_wdata <= w_merged;
                            mem_we    <= 1'b1;
                            r_tcnt    <= '0;
                            r_state   <= S_WR;
                        end
                    end else if (w_timeout) begin
                        mem_req  <= 1'b0;
                        r_state  <= S_DONE;
                        cpu_done <= 1'b1;
                        cpu_err  <= 1'b1;
                    end else begin
                        r_tcnt <= w_tcnt_next;
                    end
                end
                S_WR: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        r_state  <= S_DONE;
                        cpu_done <= 1'b1;
                    end else if (w_timeout) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        r_state  <= S_DONE;
                        cpu_done <= 1'b1;
                        cpu_err  <= 1'b1;
                    end else begin
                        r_tcnt <= w_tcnt_next;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Self-checking bench for mem_access_unit with a behavioural memory.
// Revision : 1.0
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_ld = 1'b0, cpu_st = 1'b0;
    logic [2:0]  l_mux = 3'd0;
    logic [1:0]  s_mux = 2'd0;
    logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
    logic [31:0] cpu_rdata;
    logic        cpu_done, cpu_busy, cpu_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;

    int total = 0;
    int bad = 0;

    logic [32:0] sb_q[$];
    logic [31:0] mem_arr [int unsigned];
    int          wait_cycles = 0;
    logic        no_ack = 1'b0;
    int          wcnt = 0;
    int          req_cycles = 0;
    int          addr_moved = 0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] last_addr = 32'h0;
    logic        last_we = 1'b0;
    logic [31:0] last_rd = 32'h0;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_ld(cpu_ld), .cpu_st(cpu_st),
        .l_mux(l_mux), .s_mux(s_mux), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
        .cpu_err(cpu_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    // Word memory: ack after wait_cycles, writes commit on the acked cycle.
    always @(negedge clk) begin
        mem_ack = 1'b0;
        if (mem_req && !no_ack) begin
            if (wcnt == wait_cycles) begin
                mem_ack   = 1'b1;
                last_addr = mem_addr;
                last_we   = mem_we;
                if (mem_we) mem_arr[mem_addr] = mem_wdata;
                else mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : 32'h0;
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    always @(posedge clk) begin
        if (mem_req) req_cycles++;
        if (mem_req && prev_req && (mem_addr !== prev_addr)) addr_moved++;
        prev_req  = mem_req;
        prev_addr = mem_addr;
    end

    // Scoreboard pop on each completion.
    always @(posedge clk) begin
        logic [32:0] exp;
        #1;
        if (cpu_done === 1'b1) begin
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got rdata=%h err=%b, expected no completion", cpu_rdata, cpu_err);
            end else begin
                exp = sb_q.pop_front();
                if (cpu_rdata !== exp[31:0] || cpu_err !== exp[32]) begin
                    bad++;
                    $display("FAIL completion: got rdata=%h err=%b, expected rdata=%h err=%b",
                             cpu_rdata, cpu_err, exp[31:0], exp[32]);
                end
            end
        end
    end

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] lm, input logic [1:0] lo);
        logic [15:0] h;
        logic [7:0]  b;
        h = (lo >= 2) ? w[31:16] : w[15:0];
        case (lo)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        case (lm)
            3'd1: return {{16{h[15]}}, h};
            3'd2: return {16'h0, h};
            3'd3: return {{24{b[7]}}, b};
            3'd4: return {24'h0, b};
            default: return w;
        endcase
    endfunction

    task automatic do_req(input logic ld, input logic st, input logic [2:0] lm, input logic [1:0] sm,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat, input int exp_req, input string nm);
        int cyc;
        @(negedge clk);
        cpu_ld = ld; cpu_st = st; l_mux = lm; s_mux = sm; cpu_addr = addr; cpu_wdata = wd;
        sb_q.push_back({exp_err, exp_rd});
        req_cycles = 0;
        addr_moved = 0;
        @(posedge clk); #1;
        cpu_ld = 1'b0; cpu_st = 1'b0;
        cyc = 1;
        total++;
        if (cpu_busy !== 1'b1) begin
            bad++; $display("FAIL %s_busy: got %b, expected 1", nm, cpu_busy);
        end
        while (cpu_done !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1; cyc++;
        end
        total++;
        if (cyc != exp_lat) begin
            bad++; $display("FAIL %s_latency: got %0d cycles, expected %0d", nm, cyc, exp_lat);
        end
        total++;
        if (req_cycles != exp_req) begin
            bad++; $display("FAIL %s_req_cycles: got %0d, expected %0d", nm, req_cycles, exp_req);
        end
        @(posedge clk); #1;
        total++;
        if (cpu_done !== 1'b0 || cpu_busy !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL %s_idle_after: got done=%b busy=%b req=%b, expected 0 0 0", nm, cpu_done, cpu_busy, mem_req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({cpu_rdata, cpu_done, cpu_busy, cpu_err, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            bad++; $display("FAIL reset_outputs: got rdata=%h done=%b busy=%b err=%b req=%b we=%b addr=%h wdata=%h, expected all 0",
                            cpu_rdata, cpu_done, cpu_busy, cpu_err, mem_req, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (cpu_busy !== 1'b0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL reset_idle: got busy=%b req=%b, expected 0 0", cpu_busy, mem_req);
        end
    endtask

    task automatic test_load_byte();
        logic [31:0] e;
        wait_cycles = 0;
        mem_arr[32'h100] = 32'h80FF_1234;
        do_req(1, 0, 3'd4, 2'd0, 32'h103, 32'h0, 32'h0000_0080, 0, 2, 1, "lbu");
        total++;
        if (last_addr !== 32'h100 || last_we !== 1'b0) begin
            bad++; $display("FAIL lbu_mem_addr: got addr=%h we=%b, expected 00000100 0", last_addr, last_we);
        end
        do_req(1, 0, 3'd3, 2'd0, 32'h103, 32'h0, 32'hFFFF_FF80, 0, 2, 1, "lb");
        for (int i = 0; i < 4; i++) begin
            e = ref_load(32'h80FF_1234, 3'd3 + 3'(i % 2), 2'(i));
            do_req(1, 0, 3'd3 + 3'(i % 2), 2'd0, 32'h100 + i, 32'h0, e, 0, 2, 1, "lane");
            last_rd = e;
        end
    endtask

    task automatic test_load_half_wait();
        wait_cycles = 3;
        mem_arr[32'h100] = 32'h8001_7FFF;
        do_req(1, 0, 3'd1, 2'd0, 32'h102, 32'h0, 32'hFFFF_8001, 0, 5, 4, "lh_wait");
        total++;
        if (addr_moved != 0) begin
            bad++; $display("FAIL lh_addr_stable: got %0d changes, expected 0", addr_moved);
        end
        do_req(1, 0, 3'd2, 2'd0, 32'h102, 32'h0, 32'h0000_8001, 0, 5, 4, "lhu_wait");
        last_rd = 32'h0000_8001;
        wait_cycles = 0;
        do_req(1, 0, 3'd0, 2'd0, 32'h100, 32'h0, 32'h8001_7FFF, 0, 2, 1, "lw");
        last_rd = 32'h8001_7FFF;
    endtask

    task automatic test_store();
        wait_cycles = 0;
        mem_arr[32'h200] = 32'h1122_3344;
        mem_arr[32'h204] = 32'h0;
        do_req(0, 1, 3'd0, 2'd2, 32'h201, 32'hAABB_CCDD, last_rd, 0, 3, 2, "sb");
        total++;
        if (mem_arr[32'h200] !== 32'h1122_DD44) begin
            bad++; $display("FAIL sb_merge: got %h, expected 1122dd44", mem_arr[32'h200]);
        end
        do_req(0, 1, 3'd0, 2'd1, 32'h202, 32'hAABB_CCDD, last_rd, 0, 3, 2, "sh");
        total++;
        if (mem_arr[32'h200] !== 32'hCCDD_DD44) begin
            bad++; $display("FAIL sh_merge: got %h, expected ccdddd44", mem_arr[32'h200]);
        end
        do_req(0, 1, 3'd0, 2'd0, 32'h204, 32'h1234_5678, last_rd, 0, 2, 1, "sw");
        total++;
        if (mem_arr[32'h204] !== 32'h1234_5678) begin
            bad++; $display("FAIL sw_data: got %h, expected 12345678", mem_arr[32'h204]);
        end
    endtask

    task automatic test_errors();
        do_req(0, 1, 3'd0, 2'd0, 32'h002, 32'h0, last_rd, 1, 1, 0, "sw_misalign");
        do_req(1, 0, 3'd1, 2'd0, 32'h101, 32'h0, last_rd, 1, 1, 0, "lh_misalign");
        do_req(1, 1, 3'd0, 2'd0, 32'h100, 32'h0, last_rd, 1, 1, 0, "ld_and_st");
        do_req(1, 0, 3'd5, 2'd0, 32'h100, 32'h0, last_rd, 1, 1, 0, "bad_lmux");
        do_req(0, 1, 3'd0, 2'd3, 32'h100, 32'h0, last_rd, 1, 1, 0, "bad_smux");
    endtask

    task automatic test_timeout();
        mem_arr[32'h300] = 32'hCAFE_F00D;
        @(negedge clk); no_ack = 1'b1;
        do_req(0, 1, 3'd0, 2'd0, 32'h300, 32'h1111_1111, last_rd, 1, 5, 4, "sw_timeout");
        do_req(0, 1, 3'd0, 2'd2, 32'h301, 32'h2222_2222, last_rd, 1, 5, 4, "sb_timeout");
        total++;
        if (mem_arr[32'h300] !== 32'hCAFE_F00D) begin
            bad++; $display("FAIL timeout_nowrite: got %h, expected cafef00d", mem_arr[32'h300]);
        end
        @(negedge clk); no_ack = 1'b0;
        do_req(1, 0, 3'd0, 2'd0, 32'h300, 32'h0, 32'hCAFE_F00D, 0, 2, 1, "lw_after_to");
        last_rd = 32'hCAFE_F00D;
    endtask

    task automatic test_reset_mid_write();
        mem_arr[32'h400] = 32'h0;
        @(negedge clk);
        no_ack = 1'b1;
        cpu_st = 1'b1; s_mux = 2'd0; cpu_addr = 32'h400; cpu_wdata = 32'h5555_AAAA;
        @(posedge clk); #1;
        cpu_st = 1'b0;
        @(posedge clk); #2;
        total++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1) begin
            bad++; $display("FAIL midwr_pre: got req=%b we=%b, expected 1 1", mem_req, mem_we);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if ({cpu_rdata, cpu_done, cpu_busy, cpu_err, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            bad++; $display("FAIL midwr_async_reset: got rdata=%h busy=%b req=%b we=%b addr=%h wdata=%h, expected all 0",
                            cpu_rdata, cpu_busy, mem_req, mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        no_ack = 1'b0;
        total++;
        if (mem_arr[32'h400] !== 32'h0) begin
            bad++; $display("FAIL midwr_nowrite: got %h, expected 00000000", mem_arr[32'h400]);
        end
        do_req(1, 0, 3'd0, 2'd0, 32'h300, 32'h0, 32'hCAFE_F00D, 0, 2, 1, "lw_after_rst");
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_half_wait();
        test_store();
        test_errors();
        test_timeout();
        test_reset_mid_write();
        repeat (3) @(posedge clk);
        #2;
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
